// File: rtl/count_stream_decoder_pkg.sv
// Shared types for the counter-bus monitor: FSM states, direction codes and
// the step-classification codes produced by step_classifier.
package count_stream_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        DELTA_NONE = 2'd0,
        DELTA_UP   = 2'd1,
        DELTA_DOWN = 2'd2,
        DELTA_ERR  = 2'd3
    } delta_e;

    // A 4-bit bus only ever legally moves by one in either direction, mod 16.
    function automatic delta_e classify_delta(input logic [3:0] diff);
        delta_e code;
        case (diff)
            4'd0:    code = DELTA_NONE;
            4'd1:    code = DELTA_UP;
            4'd15:   code = DELTA_DOWN;
            default: code = DELTA_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/count_stream_decoder_step_classifier.sv
// Combinational step classifier: maps the current and previous 4-bit samples
// to a delta code. Also used by the display-side checker.
module step_classifier
    import count_stream_decoder_pkg::*;
(
    input  logic [3:0] v_q_i,
    input  logic [3:0] v_prev_i,
    output delta_e     delta_o
);

    logic [3:0] diff_s;

    // Modulo-16 difference, then classification.
    always_comb begin
        diff_s  = v_q_i - v_prev_i;
        delta_o = classify_delta(diff_s);
    end

endmodule

// File: rtl/count_stream_decoder.sv
// Receive-side monitor for a 4-bit up/down counter bus: step/direction,
// period and rate class, lock tracking and illegal-jump detection.
// Optional reversal counter enabled by `define COUNT_STREAM_REV_CNT_EN.
module count_stream_decoder
    import count_stream_decoder_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int FAST_THRESH = 1000000,
    parameter int LOCK_STEPS  = 4,
    parameter int TIMEOUT     = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       value_in,
    output logic             step_pulse,
    output logic             dir,
    output logic             fast,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       rev_cnt
);

    localparam logic [CNT_W:0]   FAST_TH_C  = (CNT_W+1)'(FAST_THRESH);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LOCK_C     = 4'(LOCK_STEPS);

    state_e           state_q, state_d;
    logic [3:0]       v_q, v_prev_q, lock_q, lock_d;
    logic             vld0_q, valid_q, valid_d, have_q, have_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             dir_q, dir_d, fast_q, fast_d;
    logic             step_q, step_d, err_q, err_d, locked_q, locked_d;

    delta_e           delta_s;
    logic             is_step_s, is_err_s, step_dir_s, tmo_s;
    logic [CNT_W:0]   cnt_inc_s;

    step_classifier u_step_classifier (
        .v_q_i    (v_q),
        .v_prev_i (v_prev_q),
        .delta_o  (delta_s)
    );

    // valid_q gates out comparisons whose v_prev is not yet a real sample.
    assign is_step_s  = valid_q && ((delta_s == DELTA_UP) || (delta_s == DELTA_DOWN));
    assign is_err_s   = valid_q && (delta_s == DELTA_ERR);
    assign step_dir_s = (delta_s == DELTA_DOWN) ? DIR_DOWN : DIR_UP;
    assign tmo_s      = (cnt_q >= TMO_LAST_C);
    assign cnt_inc_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Next-state logic: FSM, period measurement and output pulses.
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        dir_d    = dir_q;
        period_d = period_q;
        fast_d   = fast_q;
        have_d   = have_q;
        valid_d  = vld0_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_inc_s[CNT_W] ? cnt_q : cnt_inc_s[CNT_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (is_step_s) begin
                    dir_d   = step_dir_s;
                    lock_d  = 4'd1;
                    state_d = ST_TRACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (is_err_s) begin
                    state_d = ST_IDLE;
                end else if (is_step_s && (step_dir_s == dir_q)) begin
                    lock_d  = lock_q + 4'd1;
                    state_d = ((lock_q + 4'd1) == LOCK_C) ? ST_LOCKED : ST_TRACK;
                end else if (is_step_s) begin
                    lock_d = 4'd1;
                    dir_d  = step_dir_s;
                end else if (tmo_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (is_err_s) begin
                    state_d = ST_IDLE;
                end else if (is_step_s && (step_dir_s != dir_q)) begin
                    lock_d  = 4'd1;
                    dir_d   = step_dir_s;
                    state_d = ST_TRACK;
                end else if (!is_step_s && tmo_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (is_step_s) begin
            step_d = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
            have_d = 1'b1;
            if (have_q) begin
                period_d = cnt_inc_s[CNT_W] ? {CNT_W{1'b1}} : cnt_inc_s[CNT_W-1:0];
                fast_d   = (cnt_inc_s < FAST_TH_C);
            end else begin
                period_d = period_q;
            end
        end else begin
            err_d = is_err_s;
        end

        // Entering IDLE forgets the last step and skips one comparison.
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            valid_d = 1'b0;
            have_d  = 1'b0;
        end else begin
            valid_d = vld0_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            v_q      <= 4'd0;
            v_prev_q <= 4'd0;
            vld0_q   <= 1'b0;
            valid_q  <= 1'b0;
            have_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            lock_q   <= 4'd0;
            period_q <= {CNT_W{1'b0}};
            dir_q    <= 1'b0;
            fast_q   <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= value_in;
            v_prev_q <= v_q;
            vld0_q   <= 1'b1;
            valid_q  <= valid_d;
            have_q   <= have_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            fast_q   <= fast_d;
            step_q   <= step_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign step_pulse = step_q;
    assign err_pulse  = err_q;
    assign dir        = dir_q;
    assign fast       = fast_q;
    assign locked     = locked_q;
    assign period     = period_q;

`ifdef COUNT_STREAM_REV_CNT_EN
    logic [7:0] rev_q, rev_d;

    // A reversal is any opposite-direction step once tracking has begun.
    always_comb begin
        if (is_step_s && (state_q != ST_IDLE) && (step_dir_s != dir_q) && (rev_q != 8'hFF)) begin
            rev_d = rev_q + 8'd1;
        end else begin
            rev_d = rev_q;
        end
    end

    // Reversal counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_q <= 8'd0;
        end else begin
            rev_q <= rev_d;
        end
    end

    assign rev_cnt = rev_q;
`else
    assign rev_cnt = 8'd0;
`endif

endmodule

// File: doc/count_stream_decoder.md
Name: count_stream_decoder

Overview:
- Receive-side monitor for the 4-bit free-running up/down counter bus in the LED counter designs.
- Watches the counter value, detects each ±1 step (mod 16) and reports direction.
- Measures the cycle period between steps, classifies the step rate as fast or slow, and flags illegal jumps.
- Used on-board to confirm the speed select and direction-toggle behaviour without a logic analyser.

Parameters:
- CNT_W, 28, width of the period counter; it saturates at 2^CNT_W-1.
- FAST_THRESH, 1000000, a measured period strictly below this value sets fast=1.
- LOCK_STEPS, 4, number of consecutive same-direction steps needed to enter LOCKED (range 2..15).
- TIMEOUT, 50000000, number of cycles without a step after which the block returns to IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- value_in  in  4  observed counter value, synchronous to clk.
- step_pulse  out  1  one-cycle pulse on each legal step.
- dir  out  1  direction of the last legal step: 0=up, 1=down.
- fast  out  1  last period was below FAST_THRESH.
- locked  out  1  state is LOCKED.
- err_pulse  out  1  one-cycle pulse on an illegal jump.
- period  out  CNT_W  cycles between the last two legal steps.
- rev_cnt  out  8  direction-reversal count (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; v_q=0; v_prev=0; period counter=0; lock counter=0; valid flag=0.
- Sampling and comparison:
  - Every clock, v_q<=value_in and v_prev<=v_q.
  - delta=(v_q-v_prev) mod 16. delta=1 is an up step; delta=15 is a down step; delta=0 is no event; any other value is an error.
  - Comparison is suppressed in the first cycle after reset and in the first cycle after entering IDLE (valid flag=0). This prevents a spurious error from the reset value.
- Latency: a value_in change before clock edge k appears as step_pulse or err_pulse after edge k+1 (2-cycle latency). All outputs are registered.
- Period counter:
  - Increments every cycle and saturates at 2^CNT_W-1.
  - On a legal step: if a previous step exists since IDLE, period<=counter+1 and fast<=(counter+1<FAST_THRESH). The counter then restarts at 0.
  - The first step after IDLE only restarts the counter; period and fast hold.
- Wrap-around: 15->0 is an up step; 0->15 is a down step. Both are legal.
- State machine:
  - IDLE: on the first legal step, set dir, lock count=1, go to TRACK. An error stays in IDLE and pulses err_pulse.
  - TRACK:
    - Same-direction step: lock count+1; when it reaches LOCK_STEPS, go to LOCKED.
    - Opposite-direction step: lock count=1, dir updates, stay in TRACK.
    - Error: go to IDLE.
  - LOCKED:
    - Same-direction step: stay.
    - Opposite-direction step: go to TRACK, lock count=1, dir updates. This is a reversal.
    - Error: go to IDLE.
  - Timeout in any non-IDLE state: counter reaches TIMEOUT-1 with no step; go to IDLE. dir, period and fast hold; locked=0.
- Simultaneous events: a step in the timeout cycle wins (no timeout). An error always overrides lock progress.
- step_pulse and err_pulse are never high in the same cycle.

Optional Feature:
- Macro: COUNT_STREAM_REV_CNT_EN.
- Defined:
  - rev_cnt increments on every direction reversal in TRACK or LOCKED, i.e. an opposite-direction step with a previous step since IDLE.
  - Saturates at 255; cleared only by reset.
- Not defined: rev_cnt is constant 0 and no counter logic is synthesised.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE=2'd0, TRACK=2'd1, LOCKED=2'd2);
  - DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - the step-classification constants (delta codes NONE, UP, DOWN, ERR).
- One sub-module: step_classifier. It is combinational and maps v_q and v_prev to the delta code. It is reused by the display-side checker.

Test Plan:
- Reset, then value_in stepped 0,1,2,3,4 every 100 cycles (FAST_THRESH=1000) -> 4 step_pulses, dir=0. locked=1 after the 4th step; period=100; fast=1; err_pulse never high.
- Up-count 13,14,15,0,1 every 2000 cycles -> wrap 15->0 is legal, dir=0, period=2000, fast=0, locked=1.
- LOCKED up, then value_in 5->4 -> step_pulse, dir=1, locked=0 (TRACK), rev_cnt=1 with COUNT_STREAM_REV_CNT_EN; rev_cnt=0 without it.
- LOCKED, value_in jumps 6->9 -> err_pulse once, state IDLE, locked=0, no step_pulse; the next 9->10 starts a new TRACK.
- LOCKED, value_in held for TIMEOUT cycles (TIMEOUT=500 in sim) -> locked=0 at cycle 500, period unchanged. A step arriving exactly at cycle 499 keeps LOCKED.
- Assert rst low mid-TRACK, asynchronously between edges -> all outputs 0 immediately. After release, the first sample does not generate err_pulse.
